general_register: RTL and testbench



---
 rtl/general_register.sv | 49 ++++
 tb/tb_general_register.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/general_register.sv
// general_register: datapath storage element with clear, load, inc/dec and
// one-bit shifts with serial fill. Used for PC, SP, IR, ACC, MAR and MDR.
module general_register #(
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cl,
   input  logic                  ld,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  sr,
   input  logic                  ir,
   input  logic                  sl,
   input  logic                  il,
   output logic [DATA_WIDTH-1:0] out
);

   logic [DATA_WIDTH-1:0] next_val;

   // Select the single highest-priority operation; lower ones are discarded.
   always_comb begin
      next_val = out;
      if (cl) begin
         next_val = '0;
      end else if (ld) begin
         next_val = in;
      end else if (inc) begin
         next_val = out + DATA_WIDTH'(1);
      end else if (dec) begin
         next_val = out - DATA_WIDTH'(1);
      end else if (sr) begin
         next_val = {ir, out[DATA_WIDTH-1:1]};
      end else if (sl) begin
         next_val = {out[DATA_WIDTH-2:0], il};
      end
   end

   // State flops drive the output directly; reset clears without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= next_val;
      end
   end

endmodule

// File: tb/tb_general_register.sv
// tb_general_register: directed and randomized checks of general_register at
// widths 6, 16 and 32 against an arithmetic reference model.
module tb_general_register;

   logic        clk;
   logic        rst_n;
   logic        cl, ld, inc, dec, sr, ir, sl, il;
   logic [5:0]  in6,  out6;
   logic [15:0] in16, out16;
   logic [31:0] in32, out32;

   longint unsigned m6, m16, m32;
   int total;
   int bad;

   general_register #(6) u_r6 (
      .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in6), .inc(inc), .dec(dec),
      .sr(sr), .ir(ir), .sl(sl), .il(il), .out(out6)
   );
   general_register #(16) u_r16 (
      .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in16), .inc(inc), .dec(dec),
      .sr(sr), .ir(ir), .sl(sl), .il(il), .out(out16)
   );
   general_register #(32) u_r32 (
      .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .in(in32), .inc(inc), .dec(dec),
      .sr(sr), .ir(ir), .sl(sl), .il(il), .out(out32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the values differ.
   task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Value the register should hold after one edge, from the operation rules.
   function automatic longint unsigned model_next(input int w, input longint unsigned v,
                                                  input longint unsigned d);
      longint unsigned mask;
      mask = (64'd1 << w) - 64'd1;
      if (!rst_n) return 0;
      if (cl)     return 0;
      if (ld)     return d & mask;
      if (inc)    return (v + 1) % (64'd1 << w);
      if (dec)    return (v + mask) % (64'd1 << w);
      if (sr)     return (longint'(ir) << (w - 1)) | (v >> 1);
      if (sl)     return ((v * 2) + longint'(il)) & mask;
      return v;
   endfunction

   task automatic set_ctl(input logic c, input logic l, input logic i, input logic d,
                          input logic r, input logic rb, input logic s, input logic lb);
      cl = c; ld = l; inc = i; dec = d; sr = r; ir = rb; sl = s; il = lb;
   endtask

   // Advance one edge, update the model and compare all three instances.
   task automatic step(input string tag);
      longint unsigned n6, n16, n32;
      n6  = model_next(6,  m6,  longint'(in6));
      n16 = model_next(16, m16, longint'(in16));
      n32 = model_next(32, m32, longint'(in32));
      @(posedge clk);
      #1;
      m6 = n6; m16 = n16; m32 = n32;
      check({tag, "_w6"},  longint'(out6),  m6);
      check({tag, "_w16"}, longint'(out16), m16);
      check({tag, "_w32"}, longint'(out32), m32);
   endtask

   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      m6 = 0; m16 = 0; m32 = 0;
      check({tag, "_w6"},  longint'(out6),  0);
      check({tag, "_w16"}, longint'(out16), 0);
      check({tag, "_w32"}, longint'(out32), 0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      m6 = 0; m16 = 0; m32 = 0;
      rst_n = 1'b1;
      in6 = '0; in16 = 16'hBEEF; in32 = '0;
      set_ctl(0, 1, 0, 0, 0, 0, 0, 0);

      // Reset mid-cycle with a load pending: output clears without an edge.
      #3;
      async_reset("rst_async");
      set_ctl(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step("hold_after_rst");
         check("hold_zero", longint'(out16), 0);
      end

      // Load, then clear beating a simultaneous load.
      in6 = 6'h3E; in16 = 16'hDEFE; in32 = 32'hDEFEDCBA;
      set_ctl(0, 1, 0, 0, 0, 0, 0, 0);
      step("load");
      check("load16", longint'(out16), 64'hDEFE);
      in16 = 16'h1234;
      set_ctl(1, 1, 0, 0, 0, 0, 0, 0);
      step("clr_over_ld");
      check("clr16", longint'(out16), 0);

      // Increment wrap at width 6, then inc beating dec.
      in6 = 6'h3E;
      set_ctl(0, 1, 0, 0, 0, 0, 0, 0);
      step("load3e");
      set_ctl(0, 0, 1, 0, 0, 0, 0, 0);
      step("inc1"); check("inc_3f", longint'(out6), 64'h3F);
      step("inc2"); check("inc_00", longint'(out6), 64'h00);
      step("inc3"); check("inc_01", longint'(out6), 64'h01);
      set_ctl(0, 0, 1, 1, 0, 0, 0, 0);
      step("incdec"); check("incdec_02", longint'(out6), 64'h02);

      // Decrement wrap at width 6.
      in6 = 6'h00;
      set_ctl(0, 1, 0, 0, 0, 0, 0, 0);
      step("load0");
      set_ctl(0, 0, 0, 1, 0, 0, 0, 0);
      step("dec1"); check("dec_3f", longint'(out6), 64'h3F);
      step("dec2"); check("dec_3e", longint'(out6), 64'h3E);

      // Shifts with serial fill at width 16.
      in16 = 16'h8001;
      set_ctl(0, 1, 0, 0, 0, 0, 0, 0);
      step("load8001");
      set_ctl(0, 0, 0, 0, 1, 1, 0, 0);
      step("sr_ir1"); check("sr_c000", longint'(out16), 64'hC000);
      set_ctl(0, 0, 0, 0, 0, 0, 1, 1);
      step("sl_il1"); check("sl_8001", longint'(out16), 64'h8001);
      set_ctl(0, 0, 0, 0, 1, 0, 1, 1);
      step("sr_sl"); check("srsl_4000", longint'(out16), 64'h4000);

      // Wide instance load/inc, then reset aborts.
      in32 = 32'hDEFEDCBA;
      set_ctl(0, 1, 0, 0, 0, 0, 0, 0);
      step("load32"); check("ld32", longint'(out32), 64'hDEFEDCBA);
      set_ctl(0, 0, 1, 0, 0, 0, 0, 0);
      step("inc32"); check("inc32", longint'(out32), 64'hDEFEDCBB);
      #2;
      async_reset("rst_mid_inc");
      step("rst_held");
      #2;
      rst_n = 1'b1;

      // Randomized controls, data and occasional asynchronous reset.
      for (int k = 0; k < 500; k++) begin
         in6  = 6'($urandom);
         in16 = 16'($urandom);
         in32 = $urandom;
         set_ctl($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0,  $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,  1'($urandom),
                 $urandom_range(0, 2) == 0,  1'($urandom));
         if ($urandom_range(0, 39) == 0) begin
            #2;
            async_reset("rnd_rst");
            if ($urandom_range(0, 1) == 1) step("rnd_rst_held");
            #2;
            rst_n = 1'b1;
         end
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
